// File: rtl/control_unit_if.sv
// control_unit_if: controller <-> datapath bundle; IR and compare flow into the
// controller, every datapath select/enable flows out of it.
interface control_unit_if;
  logic [15:0] IRout;
  logic        compare;
  logic [1:0]  Mux1_alu_B;
  logic [2:0]  Mux2_alu_A;
  logic [1:0]  Mux3_RF_wen;
  logic [2:0]  Mux4_RF_wadd;
  logic [1:0]  Mux5_RF_read2;
  logic        Mux6_RF_dataIn;
  logic [1:0]  Mux8_memwrite;
  logic        Mux9_memDataIn;
  logic        ALU_op;
  logic        CZ_en;
  logic        wIR;
  logic        wAtmp;
  logic        resetT1;
  logic [2:0]  counter;
  logic        halted;

  modport master (
    input  IRout, compare,
    output Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2,
           Mux6_RF_dataIn, Mux8_memwrite, Mux9_memDataIn, ALU_op, CZ_en,
           wIR, wAtmp, resetT1, counter, halted
  );

  modport slave (
    output IRout, compare,
    input  Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2,
           Mux6_RF_dataIn, Mux8_memwrite, Mux9_memDataIn, ALU_op, CZ_en,
           wIR, wAtmp, resetT1, counter, halted
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: multicycle Moore controller for the 16-bit RISC core.
// Define CTRL_TRAP_ILLEGAL_EN to trap unassigned opcodes in S_HALT instead of skipping them.
module control_unit #(
  parameter int RESET_STATE = 0
) (
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_F0 = 4'd0, S_F1 = 4'd1, S_P0 = 4'd2, S_P1 = 4'd3, S_D = 4'd4,
    S_EX = 4'd5, S_WB = 4'd6, S_MR = 4'd7, S_MW = 4'd8, S_LA = 4'd9,
    S_LB = 4'd10, S_BR = 4'd11, S_J = 4'd12, S_HALT = 4'd13
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000, OP_ADI = 4'b0001, OP_NDU = 4'b0010,
                         OP_LHI = 4'b0011, OP_LW  = 4'b0100, OP_SW  = 4'b0101,
                         OP_LM  = 4'b0110, OP_SM  = 4'b0111, OP_JAL = 4'b1000,
                         OP_JLR = 4'b1001, OP_BEQ = 4'b1100;

  localparam state_t RESET_ST = state_t'(RESET_STATE[3:0]);

  typedef struct packed {
    logic [1:0] mux1;
    logic [2:0] mux2;
    logic [1:0] mux3;
    logic [2:0] mux4;
    logic [1:0] mux5;
    logic       mux6;
    logic [1:0] mux8;
    logic       mux9;
    logic       alu_op;
    logic       cz_en;
    logic       wir;
    logic       watmp;
    logic       reset_t1;
    logic       halted;
  } ctrl_t;

  state_t      state_r;
  state_t      next_s;
  ctrl_t       ctrl_r;
  logic [2:0]  counter_r;
  logic        jump_r;
  logic [3:0]  op_s;
  logic        unused_ir_s;

  assign op_s        = bus.IRout[15:12];
  assign unused_ir_s = ^bus.IRout[11:0];

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_ADI, OP_NDU, OP_LHI, OP_LW, OP_SW, OP_LM, OP_SM,
      OP_JAL, OP_JLR, OP_BEQ: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Control word for a state; everything idles except T1 capture outside reset.
  function automatic ctrl_t decode(input state_t st, input logic [3:0] op, input logic rst);
    ctrl_t c;
    c          = '0;
    c.reset_t1 = ~rst;
    case (st)
      S_F0: begin c.mux5 = 2'd2; c.mux1 = 2'd2; c.mux2 = 3'd0; end
      S_F1: c.wir = 1'b1;
      S_P0: begin c.mux2 = 3'd1; c.mux1 = 2'd2; c.mux5 = 2'd2; end
      S_P1: begin c.mux4 = 3'd3; c.mux3 = 2'd1; c.mux6 = 1'b1; end
      S_D:  c.watmp = 1'b1;
      S_EX: begin
        case (op)
          OP_ADD, OP_NDU: begin
            c.mux2 = 3'd6; c.mux1 = 2'd2; c.cz_en = 1'b1; c.alu_op = op[1];
          end
          OP_ADI:         begin c.mux2 = 3'd6; c.mux1 = 2'd3; end
          OP_LHI:         begin c.mux2 = 3'd2; c.mux1 = 2'd0; end
          OP_LW, OP_SW:   begin c.mux2 = 3'd3; c.mux1 = 2'd2; end
          OP_LM, OP_SM:   begin c.mux2 = 3'd6; c.mux1 = 2'd0; end
          OP_BEQ:         begin c.mux2 = 3'd6; c.mux1 = 2'd2; end
          OP_JAL, OP_JLR: begin c.mux2 = 3'd0; c.mux1 = 2'd2; c.mux5 = 2'd2; end
          default:        c.mux2 = 3'd0;
        endcase
      end
      S_WB: begin
        case (op)
          OP_ADD, OP_NDU:         begin c.mux4 = 3'd1; c.mux3 = 2'd2; c.mux6 = 1'b1; end
          OP_ADI:                 begin c.mux4 = 3'd4; c.mux3 = 2'd1; c.mux6 = 1'b1; end
          OP_LHI, OP_JAL, OP_JLR: begin c.mux4 = 3'd0; c.mux3 = 2'd1; c.mux6 = 1'b1; end
          default:                c.mux3 = 2'd0;
        endcase
      end
      S_MR: begin c.mux4 = 3'd0; c.mux3 = 2'd1; c.mux6 = 1'b0; end
      S_MW: begin c.mux8 = 2'd1; c.mux9 = 1'b0; end
      S_LA: begin
        if (op == OP_LM) begin
          c.mux3 = 2'd3; c.mux4 = 3'd2;
        end else begin
          c.mux5 = 2'd1; c.mux9 = 1'b1; c.mux8 = 2'd2;
        end
      end
      S_LB: begin c.mux2 = 3'd1; c.mux1 = 2'd2; c.mux5 = 2'd2; end
      S_BR: begin c.mux2 = 3'd3; c.mux1 = 2'd2; c.mux5 = 2'd2; end
      S_J: begin
        // JLR takes its target straight from RF[IR[8:6]] instead of R7+imm9
        if (op == OP_JLR) begin
          c.mux2 = 3'd0; c.mux1 = 2'd2; c.mux5 = 2'd0;
        end else begin
          c.mux2 = 3'd4; c.mux1 = 2'd2; c.mux5 = 2'd2;
        end
      end
      S_HALT:  c.halted = 1'b1;
      default: c.wir = 1'b0;
    endcase
    return c;
  endfunction

  function automatic state_t next_state(input state_t st, input logic [3:0] op,
                                        input logic cmp, input logic [2:0] cnt,
                                        input logic jmp);
    state_t n;
    n = S_F0;
    case (st)
      S_F0: n = S_F1;
      S_F1: n = S_P0;
      S_P0: n = S_P1;
      S_P1: n = jmp ? S_F0 : S_D;
      S_D: begin
        if (is_legal(op)) begin
          n = S_EX;
        end else begin
`ifdef CTRL_TRAP_ILLEGAL_EN
          n = S_HALT;
`else
          n = S_F0;
`endif
        end
      end
      S_EX: begin
        case (op)
          OP_ADD, OP_ADI, OP_NDU, OP_LHI, OP_JAL, OP_JLR: n = S_WB;
          OP_LW:        n = S_MR;
          OP_SW:        n = S_MW;
          OP_LM, OP_SM: n = S_LA;
          OP_BEQ:       n = cmp ? S_BR : S_F0;
          default:      n = S_F0;
        endcase
      end
      S_WB:   n = ((op == OP_JAL) || (op == OP_JLR)) ? S_J : S_F0;
      S_MR:   n = S_F0;
      S_MW:   n = S_F0;
      S_LA:   n = S_LB;
      S_LB:   n = (cnt == 3'd7) ? S_F0 : S_LA;
      S_BR:   n = S_P1;
      S_J:    n = S_P1;
      S_HALT: n = S_HALT;
      default: n = S_F0;
    endcase
    return n;
  endfunction

  assign next_s = next_state(state_r, op_s, bus.compare, counter_r, jump_r);

  // State, LM/SM index, PC-write marker and the registered control word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= RESET_ST;
      counter_r <= 3'd0;
      jump_r    <= 1'b0;
      ctrl_r    <= decode(RESET_ST, op_s, 1'b1);
    end else begin
      state_r   <= next_s;
      // counter wraps 7->0 as the loop exits
      counter_r <= (state_r == S_LB) ? counter_r + 3'd1 : counter_r;
      jump_r    <= (state_r == S_BR) || (state_r == S_J);
      ctrl_r    <= decode(next_s, op_s, 1'b0);
    end
  end

  assign bus.Mux1_alu_B     = ctrl_r.mux1;
  assign bus.Mux2_alu_A     = ctrl_r.mux2;
  assign bus.Mux3_RF_wen    = ctrl_r.mux3;
  assign bus.Mux4_RF_wadd   = ctrl_r.mux4;
  assign bus.Mux5_RF_read2  = ctrl_r.mux5;
  assign bus.Mux6_RF_dataIn = ctrl_r.mux6;
  assign bus.Mux8_memwrite  = ctrl_r.mux8;
  assign bus.Mux9_memDataIn = ctrl_r.mux9;
  assign bus.ALU_op         = ctrl_r.alu_op;
  assign bus.CZ_en          = ctrl_r.cz_en;
  assign bus.wIR            = ctrl_r.wir;
  assign bus.wAtmp          = ctrl_r.watmp;
  assign bus.resetT1        = ctrl_r.reset_t1;
  assign bus.counter        = counter_r;
  assign bus.halted         = ctrl_r.halted;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: per-instruction phase sequences built from the instruction rules,
// with the expected control word of each phase taken from the control table.
module tb_control_unit;
  logic clk = 1'b0;
  logic reset;
  control_unit_if bus();

  control_unit #(.RESET_STATE(0)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  localparam int PH_F0 = 0, PH_F1 = 1, PH_P0 = 2, PH_P1 = 3, PH_D = 4, PH_EX = 5,
                 PH_WB = 6, PH_MR = 7, PH_MW = 8, PH_LA = 9, PH_LB = 10, PH_BR = 11,
                 PH_J = 12, PH_HALT = 13;

  typedef struct {
    int         ph;
    logic [2:0] cnt;
  } step_t;

  step_t path[$];
  int    total = 0;
  int    bad   = 0;
  bit    in_rst;

  function automatic string ph_name(input int ph);
    case (ph)
      PH_F0: return "F0";  PH_F1: return "F1";  PH_P0: return "P0";  PH_P1: return "P1";
      PH_D:  return "D";   PH_EX: return "EX";  PH_WB: return "WB";  PH_MR: return "MR";
      PH_MW: return "MW";  PH_LA: return "LA";  PH_LB: return "LB";  PH_BR: return "BR";
      PH_J:  return "J";   default: return "HALT";
    endcase
  endfunction

  function automatic bit is_illegal(input logic [3:0] op);
    return op inside {4'b1010, 4'b1011, 4'b1101, 4'b1110, 4'b1111};
  endfunction

  // Expected control word, packed in the same order as observed().
  function automatic logic [31:0] exp_out(input int ph, input logic [3:0] op,
                                          input logic [2:0] cnt, input bit rst_cyc);
    logic [1:0] b = 2'd0, wen = 2'd0, r2 = 2'd0, mw = 2'd0;
    logic [2:0] a = 3'd0, wa = 3'd0;
    logic din = 1'b0, mdi = 1'b0, alu = 1'b0, cz = 1'b0, wir = 1'b0, wat = 1'b0, hlt = 1'b0;
    case (ph)
      PH_F0: begin r2 = 2'd2; b = 2'd2; end
      PH_F1: wir = 1'b1;
      PH_P0: begin a = 3'd1; b = 2'd2; r2 = 2'd2; end
      PH_P1: begin wa = 3'd3; wen = 2'd1; din = 1'b1; end
      PH_D:  wat = 1'b1;
      PH_EX: begin
        if (op == 4'b0000 || op == 4'b0010) begin
          a = 3'd6; b = 2'd2; cz = 1'b1; alu = (op == 4'b0010);
        end
        if (op == 4'b0001) begin a = 3'd6; b = 2'd3; end
        if (op == 4'b0011) a = 3'd2;
        if (op == 4'b0100 || op == 4'b0101) begin a = 3'd3; b = 2'd2; end
        if (op == 4'b0110 || op == 4'b0111) a = 3'd6;
        if (op == 4'b1100) begin a = 3'd6; b = 2'd2; end
        if (op == 4'b1000 || op == 4'b1001) begin b = 2'd2; r2 = 2'd2; end
      end
      PH_WB: begin
        din = 1'b1;
        if (op == 4'b0000 || op == 4'b0010) begin wa = 3'd1; wen = 2'd2; end
        else if (op == 4'b0001) begin wa = 3'd4; wen = 2'd1; end
        else wen = 2'd1;
      end
      PH_MR: wen = 2'd1;
      PH_MW: mw = 2'd1;
      PH_LA: begin
        if (op == 4'b0110) begin wen = 2'd3; wa = 3'd2; end
        else begin r2 = 2'd1; mdi = 1'b1; mw = 2'd2; end
      end
      PH_LB: begin a = 3'd1; b = 2'd2; r2 = 2'd2; end
      PH_BR: begin a = 3'd3; b = 2'd2; r2 = 2'd2; end
      PH_J: begin
        b = 2'd2;
        if (op != 4'b1001) begin a = 3'd4; r2 = 2'd2; end
      end
      default: hlt = 1'b1;
    endcase
    return {7'd0, b, a, wen, wa, r2, din, mw, mdi, alu, cz, wir, wat, ~rst_cyc, cnt, hlt};
  endfunction

  function automatic logic [31:0] observed();
    return {7'd0, bus.Mux1_alu_B, bus.Mux2_alu_A, bus.Mux3_RF_wen, bus.Mux4_RF_wadd,
            bus.Mux5_RF_read2, bus.Mux6_RF_dataIn, bus.Mux8_memwrite, bus.Mux9_memDataIn,
            bus.ALU_op, bus.CZ_en, bus.wIR, bus.wAtmp, bus.resetT1, bus.counter, bus.halted};
  endfunction

  // Phase sequence of one instruction, from fetch to the cycle before the next fetch.
  task automatic build_path(input logic [3:0] op, input logic cmp);
    path.delete();
    for (int p = PH_F0; p <= PH_D; p++) path.push_back('{ph: p, cnt: 3'd0});
    if (is_illegal(op)) begin
`ifdef CTRL_TRAP_ILLEGAL_EN
      for (int k = 0; k < 5; k++) path.push_back('{ph: PH_HALT, cnt: 3'd0});
`endif
      return;
    end
    path.push_back('{ph: PH_EX, cnt: 3'd0});
    case (op)
      4'b0100: path.push_back('{ph: PH_MR, cnt: 3'd0});
      4'b0101: path.push_back('{ph: PH_MW, cnt: 3'd0});
      4'b0110, 4'b0111:
        for (int k = 0; k < 8; k++) begin
          path.push_back('{ph: PH_LA, cnt: 3'(k)});
          path.push_back('{ph: PH_LB, cnt: 3'(k)});
        end
      4'b1100:
        if (cmp) begin
          path.push_back('{ph: PH_BR, cnt: 3'd0});
          path.push_back('{ph: PH_P1, cnt: 3'd0});
        end
      4'b1000, 4'b1001: begin
        path.push_back('{ph: PH_WB, cnt: 3'd0});
        path.push_back('{ph: PH_J,  cnt: 3'd0});
        path.push_back('{ph: PH_P1, cnt: 3'd0});
      end
      default: path.push_back('{ph: PH_WB, cnt: 3'd0});
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Runs one instruction from its F0 cycle; abort_idx >= 0 asserts reset in that cycle.
  task automatic run_instr(input logic [15:0] ir, input logic cmp, input int abort_idx);
    logic [3:0] op;
    int         mw_ones;
    int         abort_at;
    op       = ir[15:12];
    mw_ones  = 0;
    abort_at = abort_idx;
    build_path(op, cmp);
    if (path[path.size()-1].ph == PH_HALT) abort_at = path.size() - 1;
    bus.IRout = ir;
    foreach (path[i]) begin
      bus.compare = (path[i].ph == PH_EX && op == 4'b1100) ? cmp : 1'($urandom_range(0, 1));
      check($sformatf("%s op=%b idx=%0d", ph_name(path[i].ph), op, i), observed(),
            exp_out(path[i].ph, op, path[i].cnt, in_rst && (i == 0)));
      if (bus.Mux8_memwrite == 2'd1) mw_ones++;
      if (i == 0 && in_rst) begin
        reset  = 1'b0;
        in_rst = 1'b0;
      end
      if (i == abort_at) begin
        reset = 1'b1;
        step();
        in_rst = 1'b1;
        return;
      end
      step();
    end
    if (op == 4'b0101) check("sw_memwrite_cycles", 32'(mw_ones), 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    bus.IRout   = 16'h0000;
    bus.compare = 1'b0;
    step();
    step();
    in_rst = 1'b1;

    run_instr({4'b0000, 3'd1, 3'd2, 3'd3, 3'd0}, 1'b0, -1);   // ADD R3 <- R1+R2
    run_instr({4'b0001, 3'd1, 3'd2, 6'd5},       1'b0, -1);   // ADI
    run_instr({4'b0010, 3'd4, 3'd5, 3'd6, 3'd0}, 1'b0, -1);   // NDU
    run_instr({4'b0011, 3'd2, 9'h1AB},           1'b0, -1);   // LHI
    run_instr({4'b0101, 3'd1, 3'd2, 6'd3},       1'b0, -1);   // SW R1 -> [R2+3]
    run_instr({4'b0100, 3'd4, 3'd2, 6'd3},       1'b0, -1);   // LW R4 <- [R2+3]
    run_instr({4'b0110, 3'd1, 1'b0, 8'h81},      1'b0, -1);   // LM R0,R7
    run_instr({4'b0111, 3'd2, 1'b0, 8'hFF},      1'b0, -1);   // SM all
    run_instr({4'b1100, 3'd1, 3'd2, 6'd4},       1'b1, -1);   // BEQ taken
    run_instr({4'b1100, 3'd1, 3'd2, 6'd4},       1'b0, -1);   // BEQ not taken
    run_instr({4'b1000, 3'd5, 9'd17},            1'b0, -1);   // JAL
    run_instr({4'b1001, 3'd5, 3'd3, 6'd0},       1'b0, -1);   // JLR
    run_instr(16'hF123,                          1'b0, -1);   // illegal 1111
    run_instr({4'b0110, 3'd1, 1'b0, 8'h81},      1'b0, 12);   // LM, reset in LA with counter 3
    run_instr({4'b0000, 3'd1, 3'd2, 3'd3, 3'd0}, 1'b0, -1);

    for (int n = 0; n < 60; n++) begin
      run_instr(16'($urandom), 1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
